image_process_engine: RTL and testbench
=======================================

Name: image_process_engine

Overview:
- Parametrised successor to the fixed 64x64 brightness-add image path.
- Reads pixels from an external source image memory and applies a selectable per-pixel operation: wrap add, saturating add, saturating subtract or invert.
- Writes results into an internal double-buffered frame store. The VGA scan-out side reads the front buffer while the back buffer is rebuilt.
- Re-processes automatically when brightness or mode changes, which the previous generation could not do.

Parameters:
- IMG_W, 64, image width in pixels
- IMG_H, 64, image height in pixels
- PIX_W, 8, pixel/brightness width in bits
- NPIX, IMG_W*IMG_H, pixel count (derived)
- ADDR_W, $clog2(NPIX), pixel address width (derived, 12 at defaults)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; requests a processing pass
- brightness  in  PIX_W  operand for add/subtract modes
- mode  in  2  0=add wrap, 1=add saturate, 2=subtract saturate, 3=invert
- src_addr  out  ADDR_W  source image memory address
- src_data  in  PIX_W  source pixel; valid exactly 1 cycle after src_addr
- frame_sync  in  1  one-cycle pulse at start of vertical blank
- rd_addr  in  ADDR_W  scan-out read address
- rd_data  out  PIX_W  front-buffer pixel, registered, 1-cycle latency
- busy  out  1  processing pass in progress
- swap_pending  out  1  back buffer complete, awaiting frame_sync
- front_valid  out  1  at least one swap has occurred since reset
- frame_count  out  8  number of completed swaps, wraps 255->0

Behaviour:
- Reset (async, rst=1). All of the following take effect immediately:
  - state=IDLE; src_addr=0; rd_data=0; busy=0; swap_pending=0; front_valid=0; frame_count=0; front_sel=0; dirty=0.
  - Buffer RAM contents are not reset.
- rd_data while front_valid=0 is 0, regardless of RAM content.
- Parameter latch: brightness and mode are captured into op_b/op_mode on the cycle a pass starts. They are constant for the whole pass.
- dirty flag:
  - Set when brightness or mode differs from the value registered on the previous cycle.
  - The change comparison is disabled in the reset-release cycle.
  - dirty=1 in IDLE acts as start.
- FSM:
  - IDLE: go to RD when start=1 or dirty=1. In that cycle: latch op_b/op_mode, clear dirty, set pix=0, set busy=1.
  - RD: drive src_addr=pix; go to CALC.
  - CALC: src_data valid; compute result into a register; go to WR.
  - WR: write result to back buffer (buffer ~front_sel) at pix.
    - If pix==NPIX-1: go to DONE, busy=0, swap_pending=1.
    - Otherwise: pix+1, go to RD.
  - DONE: on frame_sync=1: toggle front_sel; swap_pending=0; front_valid=1; frame_count+1; go to IDLE.
- Pass timing: exactly 3 cycles per pixel. busy high for 3*NPIX cycles (12288 at defaults).
- Arithmetic, where s=src_data and b=op_b, unsigned PIX_W:
  - mode 0: (s+b) mod 2^PIX_W.
  - mode 1: min(s+b, 2^PIX_W-1).
  - mode 2: max(s-b, 0).
  - mode 3: ~s; b is ignored.
- Simultaneous and boundary events:
  - start while busy or DONE: ignored, no queueing.
  - Param change while busy or DONE: sets dirty. The current pass completes with the old latched values. After the swap, IDLE immediately starts a new pass.
  - frame_sync outside DONE: no effect.
  - frame_sync in the same cycle as the WR of the last pixel: not honoured. Swap occurs on the next frame_sync.
  - Reset mid-pass: abort. The half-written back buffer is never shown.
- Scan-out: rd_data <= front[rd_addr] every cycle.
  - It is registered, so a swap affects rd_data starting 2 cycles after the frame_sync edge.
  - Reads never stall, and never collide with writes because they target different buffers.

Test Plan:
- Reset then start, mode 0, brightness 0x0F, src[0]=0xF8, src[1]=0x10 -> busy for 12288 cycles, then swap_pending=1. After frame_sync: front_valid=1, frame_count=1, rd_data(0)=0x07, rd_data(1)=0x1F.
- Mode 1/2/3 passes:
  - src 0xF8, b 0x0F, mode 1 -> 0xFF.
  - src 0x05, b 0x0F, mode 2 -> 0x00.
  - src 0x3C, mode 3 -> 0xC3.
- Change brightness 0x0F->0x20 mid-pass (cycle 5000) -> first swap shows +0x0F results. A second pass starts 1 cycle after the swap, and after the next frame_sync rd_data(1)=0x30.
- Hold frame_sync low for 20000 cycles after completion -> swap_pending stays 1, rd_data stays at old values, frame_count unchanged. Pulse start during DONE -> no effect.
- Assert rst at pixel 2000 of the second pass -> all outputs 0 immediately, including rd_data, front_valid and frame_count.
- Parameterise IMG_W=4, IMG_H=2 -> busy exactly 24 cycles, src_addr sequence 0..7, frame_count wraps 255->0 after 256 swaps.

Source files
------------

// File: rtl/image_process_engine.sv
// Source-to-frame-store image engine: reads an external source image, applies a
// per-pixel brightness/invert op and rebuilds the back buffer of a double-buffered store.
module image_process_engine #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int PIX_W  = 8,
    parameter int NPIX   = IMG_W * IMG_H,
    parameter int ADDR_W = $clog2(NPIX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PIX_W-1:0]  brightness,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_data,
    input  logic              frame_sync,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              swap_pending,
    output logic              front_valid,
    output logic [7:0]        frame_count
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_DONE} state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  pix;
    logic [PIX_W-1:0]   op_b, result, alu, prev_b;
    logic [1:0]         op_mode, prev_mode;
    logic               dirty, cmp_en, front_sel;
    logic               go, last;
    logic [PIX_W:0]     sum, diff;

    logic [PIX_W-1:0]   mem0 [NPIX];
    logic [PIX_W-1:0]   mem1 [NPIX];

    assign go       = start | dirty;
    assign last     = (pix == ADDR_W'(NPIX - 1));
    assign src_addr = pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (go) state_nx = S_RD;
            S_RD:    state_nx = S_CALC;
            S_CALC:  state_nx = S_WR;
            S_WR:    state_nx = last ? S_DONE : S_RD;
            S_DONE:  if (frame_sync) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Widened by one bit so carry/borrow flags saturation.
    always_comb begin
        sum  = {1'b0, src_data} + {1'b0, op_b};
        diff = {1'b0, src_data} - {1'b0, op_b};
        case (op_mode)
            2'd0:    alu = sum[PIX_W-1:0];
            2'd1:    alu = sum[PIX_W]  ? '1 : sum[PIX_W-1:0];
            2'd2:    alu = diff[PIX_W] ? '0 : diff[PIX_W-1:0];
            default: alu = ~src_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix          <= '0;
            op_b         <= '0;
            op_mode      <= '0;
            result       <= '0;
            busy         <= 1'b0;
            swap_pending <= 1'b0;
            front_valid  <= 1'b0;
            frame_count  <= '0;
            front_sel    <= 1'b0;
            dirty        <= 1'b0;
            prev_b       <= '0;
            prev_mode    <= '0;
            cmp_en       <= 1'b0;
        end else begin
            prev_b    <= brightness;
            prev_mode <= mode;
            cmp_en    <= 1'b1;
            // The first cycle after reset has no valid previous value to compare.
            if (cmp_en && (brightness != prev_b || mode != prev_mode))
                dirty <= 1'b1;
            case (state)
                S_IDLE: if (go) begin
                    op_b    <= brightness;
                    op_mode <= mode;
                    dirty   <= 1'b0;
                    pix     <= '0;
                    busy    <= 1'b1;
                end
                S_CALC: result <= alu;
                S_WR: begin
                    if (last) begin
                        busy         <= 1'b0;
                        swap_pending <= 1'b1;
                    end else begin
                        pix <= pix + ADDR_W'(1);
                    end
                end
                S_DONE: if (frame_sync) begin
                    front_sel    <= ~front_sel;
                    swap_pending <= 1'b0;
                    front_valid  <= 1'b1;
                    frame_count  <= frame_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Back buffer is the one not selected for scan-out.
    always_ff @(posedge clk) begin
        if (state == S_WR) begin
            if (front_sel) mem0[pix] <= result;
            else           mem1[pix] <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              rd_data <= '0;
        else if (!front_valid) rd_data <= '0;
        else                  rd_data <= front_sel ? mem1[rd_addr] : mem0[rd_addr];
    end

endmodule

// File: tb/tb_image_process_engine.sv
// Directed bench: a 64x64 instance for long-pass/hold/reset scenarios and a
// 4x2 instance for table-driven arithmetic vectors and frame_count wrap.
module tb_image_process_engine;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- 64x64 instance ----------------
    logic        rst, start, frame_sync, busy, swap_pending, front_valid;
    logic [7:0]  brightness, src_data, rd_data, frame_count;
    logic [1:0]  mode;
    logic [11:0] src_addr, rd_addr;
    logic [7:0]  srcmem [4096];

    image_process_engine dut (
        .clk(clk), .rst(rst), .start(start), .brightness(brightness), .mode(mode),
        .src_addr(src_addr), .src_data(src_data), .frame_sync(frame_sync),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .swap_pending(swap_pending),
        .front_valid(front_valid), .frame_count(frame_count)
    );

    always @(posedge clk) src_data <= srcmem[src_addr];

    // ---------------- 4x2 instance ----------------
    logic        rst_s, start_s, frame_sync_s, busy_s, swap_pending_s, front_valid_s;
    logic [7:0]  brightness_s, src_data_s, rd_data_s, frame_count_s;
    logic [1:0]  mode_s;
    logic [2:0]  src_addr_s, rd_addr_s;
    logic [7:0]  srcmem_s [8];

    image_process_engine #(.IMG_W(4), .IMG_H(2)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .brightness(brightness_s), .mode(mode_s),
        .src_addr(src_addr_s), .src_data(src_data_s), .frame_sync(frame_sync_s),
        .rd_addr(rd_addr_s), .rd_data(rd_data_s), .busy(busy_s), .swap_pending(swap_pending_s),
        .front_valid(front_valid_s), .frame_count(frame_count_s)
    );

    always @(posedge clk) src_data_s <= srcmem_s[src_addr_s];

    typedef struct {
        logic [1:0] m;
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];
    logic [2:0] addr_q[$];

    task automatic rd_big(input logic [11:0] a, output logic [7:0] d);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic rd_small(input logic [2:0] a, output logic [7:0] d);
        rd_addr_s = a;
        @(negedge clk);
        d = rd_data_s;
    endtask

    task automatic fs_big();
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic fs_small();
        frame_sync_s = 1'b1;
        @(negedge clk);
        frame_sync_s = 1'b0;
    endtask

    task automatic pass_small(input logic [1:0] m, input logic [7:0] b, output int cnt);
        mode_s       = m;
        brightness_s = b;
        start_s      = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cnt = 0;
        while (busy_s === 1'b1 && cnt < 100) begin
            cnt++;
            if (addr_q.size() == 0 || addr_q[$] != src_addr_s) addr_q.push_back(src_addr_s);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] d;
        int cnt, swaps_s;
        logic bad_sp, bad_busy, bad_fc, bad_rd;

        vecs[0]  = '{2'd0, 8'h0F, 8'hF8, 8'h07};
        vecs[1]  = '{2'd0, 8'h0F, 8'h10, 8'h1F};
        vecs[2]  = '{2'd1, 8'h0F, 8'hF8, 8'hFF};
        vecs[3]  = '{2'd1, 8'h0F, 8'h10, 8'h1F};
        vecs[4]  = '{2'd2, 8'h0F, 8'h05, 8'h00};
        vecs[5]  = '{2'd2, 8'h0F, 8'h20, 8'h11};
        vecs[6]  = '{2'd3, 8'h0F, 8'h3C, 8'hC3};
        vecs[7]  = '{2'd3, 8'h00, 8'h00, 8'hFF};
        vecs[8]  = '{2'd1, 8'hFF, 8'h00, 8'hFF};
        vecs[9]  = '{2'd2, 8'h00, 8'hFF, 8'hFF};
        vecs[10] = '{2'd1, 8'h01, 8'hFE, 8'hFF};
        vecs[11] = '{2'd0, 8'h01, 8'hFF, 8'h00};

        for (int i = 0; i < 4096; i++) srcmem[i] = 8'(i);
        srcmem[0] = 8'hF8; srcmem[1] = 8'h10; srcmem[4095] = 8'h80;
        for (int i = 0; i < 8; i++) srcmem_s[i] = 8'h00;

        rst = 1'b1; start = 1'b0; frame_sync = 1'b0; rd_addr = '0;
        brightness = 8'h0F; mode = 2'd0;
        rst_s = 1'b1; start_s = 1'b0; frame_sync_s = 1'b0; rd_addr_s = '0;
        brightness_s = 8'h00; mode_s = 2'd0;

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_swap_pending", swap_pending, 0);
        chk("rst_front_valid", front_valid, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_src_addr", src_addr, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_autostart_after_reset", busy, 0);

        // Pass 1: brightness changes mid-pass; the pass keeps +0x0F.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            cnt++;
            if (cnt == 5000) brightness = 8'h20;
            @(negedge clk);
        end
        chk("pass1_busy_cycles", cnt, 12288);
        chk("pass1_swap_pending", swap_pending, 1);

        bad_sp = 0; bad_busy = 0; bad_fc = 0; bad_rd = 0;
        rd_addr = 12'd1;
        for (int i = 0; i < 20000; i++) begin
            start = (i == 100);
            @(negedge clk);
            if (swap_pending !== 1'b1) bad_sp = 1;
            if (busy !== 1'b0) bad_busy = 1;
            if (frame_count !== 8'd0) bad_fc = 1;
            if (rd_data !== 8'd0) bad_rd = 1;
        end
        start = 1'b0;
        chk("hold_swap_pending_dropped", bad_sp, 0);
        chk("hold_busy_seen", bad_busy, 0);
        chk("hold_frame_count_moved", bad_fc, 0);
        chk("hold_rd_data_moved", bad_rd, 0);

        fs_big();
        chk("swap1_front_valid", front_valid, 1);
        chk("swap1_frame_count", frame_count, 1);
        chk("swap1_swap_pending", swap_pending, 0);
        chk("swap1_busy_same_cycle", busy, 0);
        @(negedge clk);
        chk("dirty_restart_busy", busy, 1);
        rd_big(12'd0, d);    chk("pass1_rd0", d, 8'h07);
        rd_big(12'd1, d);    chk("pass1_rd1", d, 8'h1F);
        rd_big(12'd4095, d); chk("pass1_rd_last", d, 8'h8F);

        cnt = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            cnt++;
            @(negedge clk);
        end
        chk("pass2_finished", busy, 0);
        chk("pass2_swap_pending", swap_pending, 1);
        rd_big(12'd1, d); chk("pass2_old_front_rd1", d, 8'h1F);
        fs_big();
        chk("swap2_frame_count", frame_count, 2);
        rd_big(12'd1, d);    chk("pass2_rd1", d, 8'h30);
        rd_big(12'd0, d);    chk("pass2_rd0", d, 8'h18);
        rd_big(12'd4095, d); chk("pass2_rd_last", d, 8'hA0);
        chk("no_restart_without_change", busy, 0);

        // Pass 3 aborted by reset around pixel 2000.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6000) @(negedge clk);
        chk("pass3_busy_mid", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_swap_pending", swap_pending, 0);
        chk("abort_front_valid", front_valid, 0);
        chk("abort_frame_count", frame_count, 0);
        chk("abort_rd_data", rd_data, 0);
        chk("abort_src_addr", src_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_abort_busy", busy, 0);
        chk("post_abort_front_valid", front_valid, 0);
        chk("post_abort_rd_data", rd_data, 0);

        // ---------------- small instance ----------------
        @(negedge clk);
        rst_s = 1'b0;
        repeat (2) @(negedge clk);
        swaps_s = 0;
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < 8; i++) srcmem_s[i] = vecs[v].s;
            addr_q.delete();
            pass_small(vecs[v].m, vecs[v].b, cnt);
            if (v == 0) begin
                chk("small_busy_cycles", cnt, 24);
                chk("small_addr_count", addr_q.size(), 8);
                for (int i = 0; i < 8 && i < addr_q.size(); i++)
                    chk($sformatf("small_addr_seq[%0d]", i), addr_q[i], i);
            end
            chk($sformatf("vec%0d_swap_pending", v), swap_pending_s, 1);
            fs_small();
            swaps_s++;
            chk($sformatf("vec%0d_frame_count", v), frame_count_s, swaps_s);
            rd_small(3'd0, d); chk($sformatf("vec%0d_rd0", v), d, vecs[v].exp);
            rd_small(3'd7, d); chk($sformatf("vec%0d_rd7", v), d, vecs[v].exp);
        end

        // frame_sync coinciding with the last pixel's write is not honoured.
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cnt = 0;
        while (busy_s === 1'b1 && cnt < 100) begin
            cnt++;
            frame_sync_s = (cnt == 24);
            @(negedge clk);
        end
        frame_sync_s = 1'b0;
        chk("fs_at_last_wr_pending", swap_pending_s, 1);
        chk("fs_at_last_wr_count", frame_count_s, swaps_s);
        repeat (3) @(negedge clk);
        chk("fs_at_last_wr_still_pending", swap_pending_s, 1);
        fs_small();
        swaps_s++;
        chk("fs_after_last_wr_count", frame_count_s, swaps_s);

        while (swaps_s < 256) begin
            pass_small(2'd0, 8'h01, cnt);
            fs_small();
            swaps_s++;
            if (swaps_s == 255) chk("wrap_count_255", frame_count_s, 255);
            if (swaps_s == 256) chk("wrap_count_0", frame_count_s, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
